// File: rtl/can_frame_sequencer.sv
// can_frame_sequencer: bit-level field sequencer for the CAN receive path.
// Consumes one sampled bit per sp strobe and removes dynamic stuff bits.
// Walks the base-format Classical/FD header and emits data bytes, then hands
// off to the CRC/tail logic and waits for 11 recessive bits.
module can_frame_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sp,
  input  logic        rx_bit,
  output logic        busy,
  output logic [10:0] id,
  output logic        rtr,
  output logic        edl,
  output logic        brs,
  output logic        esi,
  output logic [3:0]  dlc,
  output logic        remote,
  output logic        hdr_valid,
  output logic [7:0]  data_byte,
  output logic        data_valid,
  output logic        frame_done,
  output logic        stuff_err,
  output logic        form_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_RTR, S_IDE, S_FDF, S_RES, S_BRS, S_ESI, S_DLC,
    S_DATA, S_TAIL, S_ERROR
  } state_e;

  // Index of the final data bit for a non-empty data field.
  function automatic logic [8:0] last_bit_idx(input logic fd, input logic [3:0] d);
    logic [3:0] dm1;
    dm1 = d - 4'd1;
    if (d <= 4'd8) return {2'b00, dm1, 3'b111};
    if (!fd)       return 9'd63;
    case (d)
      4'd9:    return 9'd95;
      4'd10:   return 9'd127;
      4'd11:   return 9'd159;
      4'd12:   return 9'd191;
      4'd13:   return 9'd255;
      4'd14:   return 9'd383;
      default: return 9'd511;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  last_q, last_d;
  logic [6:0]  sr_q, sr_d;
  logic        run_val_q, run_val_d;
  logic [2:0]  run_cnt_q, run_cnt_d;
  logic [3:0]  ones_q, ones_d;
  logic        busy_q, busy_d;
  logic [10:0] id_q, id_d;
  logic        rtr_q, rtr_d, edl_q, edl_d, brs_q, brs_d, esi_q, esi_d;
  logic [3:0]  dlc_q, dlc_d;
  logic        remote_q, remote_d;
  logic [7:0]  data_byte_q, data_byte_d;
  logic        hdr_valid_q, hdr_valid_d, data_valid_q, data_valid_d;
  logic        frame_done_q, frame_done_d, stuff_err_q, stuff_err_d;
  logic        form_err_q, form_err_d;
  logic [3:0]  dlc_new;
  logic        remote_new;

  assign dlc_new    = {dlc_q[2:0], rx_bit};
  assign remote_new = !edl_q && rtr_q;

  // Next-state: destuffing ahead of field decode, all gated by sp.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    sr_d         = sr_q;
    run_val_d    = run_val_q;
    run_cnt_d    = run_cnt_q;
    ones_d       = ones_q;
    busy_d       = busy_q;
    id_d         = id_q;
    rtr_d        = rtr_q;
    edl_d        = edl_q;
    brs_d        = brs_q;
    esi_d        = esi_q;
    dlc_d        = dlc_q;
    remote_d     = remote_q;
    data_byte_d  = data_byte_q;
    hdr_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    stuff_err_d  = 1'b0;
    form_err_d   = 1'b0;
    if (sp) begin
      if (state_q == S_IDLE) begin
        if (!rx_bit) begin
          state_d   = S_ID;
          busy_d    = 1'b1;
          id_d      = '0;
          rtr_d     = 1'b0;
          edl_d     = 1'b0;
          brs_d     = 1'b0;
          esi_d     = 1'b0;
          dlc_d     = '0;
          remote_d  = 1'b0;
          cnt_d     = '0;
          run_val_d = 1'b0;
          run_cnt_d = 3'd1;
        end
      end else if (state_q == S_TAIL || state_q == S_ERROR) begin
        if (rx_bit) begin
          if (ones_q == 4'd10) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ones_d  = '0;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else begin
          ones_d = '0;
        end
      end else if (run_cnt_q == 3'd5) begin
        // Stuff slot: a complementary bit is dropped, an equal one is an error.
        if (rx_bit != run_val_q) begin
          run_val_d = rx_bit;
          run_cnt_d = 3'd1;
        end else begin
          stuff_err_d = 1'b1;
          state_d     = S_ERROR;
          ones_d      = '0;
        end
      end else begin
        if (rx_bit == run_val_q) begin
          run_cnt_d = run_cnt_q + 3'd1;
        end else begin
          run_val_d = rx_bit;
          run_cnt_d = 3'd1;
        end
        case (state_q)
          S_ID: begin
            id_d  = {id_q[9:0], rx_bit};
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == 9'd10) state_d = S_RTR;
          end
          S_RTR: begin
            rtr_d   = rx_bit;
            state_d = S_IDE;
          end
          S_IDE: begin
            if (rx_bit) begin
              form_err_d = 1'b1;
              state_d    = S_ERROR;
              ones_d     = '0;
            end else begin
              state_d = S_FDF;
            end
          end
          S_FDF: begin
            edl_d   = rx_bit;
            cnt_d   = '0;
            state_d = rx_bit ? S_RES : S_DLC;
          end
          S_RES: begin
            if (rx_bit) begin
              form_err_d = 1'b1;
              state_d    = S_ERROR;
              ones_d     = '0;
            end else begin
              state_d = S_BRS;
            end
          end
          S_BRS: begin
            brs_d   = rx_bit;
            state_d = S_ESI;
          end
          S_ESI: begin
            esi_d   = rx_bit;
            cnt_d   = '0;
            state_d = S_DLC;
          end
          S_DLC: begin
            dlc_d = dlc_new;
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == 9'd3) begin
              hdr_valid_d = 1'b1;
              remote_d    = remote_new;
              cnt_d       = '0;
              last_d      = last_bit_idx(edl_q, dlc_new);
              if (remote_new || dlc_new == 4'd0) begin
                frame_done_d = 1'b1;
                state_d      = S_TAIL;
                ones_d       = '0;
              end else begin
                state_d = S_DATA;
              end
            end
          end
          S_DATA: begin
            sr_d  = {sr_q[5:0], rx_bit};
            cnt_d = cnt_q + 9'd1;
            if (cnt_q[2:0] == 3'd7) begin
              data_byte_d  = {sr_q, rx_bit};
              data_valid_d = 1'b1;
            end
            if (cnt_q == last_q) begin
              frame_done_d = 1'b1;
              state_d      = S_TAIL;
              ones_d       = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_q       <= '0;
      sr_q         <= '0;
      run_val_q    <= 1'b0;
      run_cnt_q    <= '0;
      ones_q       <= '0;
      busy_q       <= 1'b0;
      id_q         <= '0;
      rtr_q        <= 1'b0;
      edl_q        <= 1'b0;
      brs_q        <= 1'b0;
      esi_q        <= 1'b0;
      dlc_q        <= '0;
      remote_q     <= 1'b0;
      data_byte_q  <= '0;
      hdr_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      form_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      sr_q         <= sr_d;
      run_val_q    <= run_val_d;
      run_cnt_q    <= run_cnt_d;
      ones_q       <= ones_d;
      busy_q       <= busy_d;
      id_q         <= id_d;
      rtr_q        <= rtr_d;
      edl_q        <= edl_d;
      brs_q        <= brs_d;
      esi_q        <= esi_d;
      dlc_q        <= dlc_d;
      remote_q     <= remote_d;
      data_byte_q  <= data_byte_d;
      hdr_valid_q  <= hdr_valid_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      stuff_err_q  <= stuff_err_d;
      form_err_q   <= form_err_d;
    end
  end

  assign busy       = busy_q;
  assign id         = id_q;
  assign rtr        = rtr_q;
  assign edl        = edl_q;
  assign brs        = brs_q;
  assign esi        = esi_q;
  assign dlc        = dlc_q;
  assign remote     = remote_q;
  assign hdr_valid  = hdr_valid_q;
  assign data_byte  = data_byte_q;
  assign data_valid = data_valid_q;
  assign frame_done = frame_done_q;
  assign stuff_err  = stuff_err_q;
  assign form_err   = form_err_q;

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Directed bench for can_frame_sequencer: frames are built as raw bit lists,
// stuffed on the fly while driving, and decoded results compared to constants.
module tb_can_frame_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, sp = 1'b0, rx_bit = 1'b1;
  logic        busy, rtr, edl, brs, esi, remote, hdr_valid, data_valid;
  logic        frame_done, stuff_err, form_err;
  logic [10:0] id;
  logic [3:0]  dlc;
  logic [7:0]  data_byte;

  can_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sp(sp), .rx_bit(rx_bit), .busy(busy), .id(id),
    .rtr(rtr), .edl(edl), .brs(brs), .esi(esi), .dlc(dlc), .remote(remote),
    .hdr_valid(hdr_valid), .data_byte(data_byte), .data_valid(data_valid),
    .frame_done(frame_done), .stuff_err(stuff_err), .form_err(form_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int gap_g = 0;
  logic bits_q[$];

  // Event recorder (cumulative; tests work on deltas).
  int hdr_n = 0, dv_n = 0, fd_n = 0, fd_dv = 0, fd_hdr = 0, fd_at_dv = 0;
  int serr_n = 0, ferr_n = 0;
  logic [7:0]  bytes_q[$];
  logic [10:0] h_id = '0;
  logic        h_edl = 1'b0, h_brs = 1'b0, h_esi = 1'b0, h_rem = 1'b0;
  logic [3:0]  h_dlc = '0;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_n <= dv_n + 1;
      bytes_q.push_back(data_byte);
    end
    if (hdr_valid) begin
      hdr_n <= hdr_n + 1;
      h_id  <= id; h_edl <= edl; h_brs <= brs; h_esi <= esi;
      h_dlc <= dlc; h_rem <= remote;
    end
    if (frame_done) begin
      fd_n     <= fd_n + 1;
      fd_at_dv <= dv_n + (data_valid ? 1 : 0);
      if (data_valid) fd_dv <= fd_dv + 1;
      if (hdr_valid)  fd_hdr <= fd_hdr + 1;
    end
    if (stuff_err) serr_n <= serr_n + 1;
    if (form_err)  ferr_n <= ferr_n + 1;
  end

  int s_hdr, s_dv, s_fd, s_fddv, s_fdhdr, s_serr, s_ferr, s_bytes;
  task automatic snap();
    s_hdr = hdr_n; s_dv = dv_n; s_fd = fd_n; s_fddv = fd_dv; s_fdhdr = fd_hdr;
    s_serr = serr_n; s_ferr = ferr_n; s_bytes = bytes_q.size();
  endtask

  task automatic push(input logic [10:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endtask

  // Unstuffed base-format header; stops after a bit that should abort.
  task automatic build_hdr(input logic [10:0] fid, input logic frtr, input logic ide,
                           input logic fdf, input logic res, input logic fbrs,
                           input logic fesi, input logic [3:0] fdlc);
    bits_q.delete();
    push(11'd0, 1); push(fid, 11); push({10'd0, frtr}, 1); push({10'd0, ide}, 1);
    if (ide) return;
    push({10'd0, fdf}, 1);
    if (fdf) begin
      push({10'd0, res}, 1);
      if (res) return;
      push({10'd0, fbrs}, 1); push({10'd0, fesi}, 1);
    end
    push({7'd0, fdlc}, 4);
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    sp = 1'b1; rx_bit = b;
    if (gap_g > 0) begin
      @(negedge clk);
      sp = 1'b0;
      repeat (gap_g - 1) @(negedge clk);
    end
  endtask

  task automatic sp_off();
    @(negedge clk);
    sp = 1'b0; rx_bit = 1'b1;
    #1;
  endtask

  // Drives the first nmax bits (all if negative), inserting stuff bits between them.
  task automatic send_bits(input bit do_stuff, input int nmax);
    int n, run_c;
    logic run_v;
    n = (nmax < 0) ? bits_q.size() : nmax;
    run_c = 0; run_v = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_bit(bits_q[i]);
      if (run_c != 0 && bits_q[i] == run_v) run_c++;
      else begin run_v = bits_q[i]; run_c = 1; end
      if (do_stuff && run_c == 5 && i < n - 1) begin
        drive_bit(~run_v); run_v = ~run_v; run_c = 1;
      end
    end
    sp_off();
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
    sp_off();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    total++; if ({busy, id, rtr, edl, brs, esi, dlc, remote, data_byte} !== 29'd0) begin bad++; $display("FAIL reset_state: got %h want 0", {busy, id, rtr, edl, brs, esi, dlc, remote, data_byte}); end
    total++; if ({hdr_valid, data_valid, frame_done, stuff_err, form_err} !== 5'd0) begin bad++; $display("FAIL reset_pulses: got %b want 00000", {hdr_valid, data_valid, frame_done, stuff_err, form_err}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_classical();
    snap();
    build_hdr(11'h123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    push(11'hA5, 8); push(11'h3C, 8);
    send_bits(1'b1, -1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cls_busy: got %b want 1", busy); end
    total++; if (hdr_n - s_hdr !== 1) begin bad++; $display("FAIL cls_hdr_cnt: got %0d want 1", hdr_n - s_hdr); end
    total++; if ({h_id, h_edl, h_dlc} !== {11'h123, 1'b0, 4'd2}) begin bad++; $display("FAIL cls_hdr: got id=%h edl=%b dlc=%0d want id=123 edl=0 dlc=2", h_id, h_edl, h_dlc); end
    total++; if (dv_n - s_dv !== 2) begin bad++; $display("FAIL cls_dv_cnt: got %0d want 2", dv_n - s_dv); end
    total++; if (bytes_q.size() < s_bytes + 2 || bytes_q[s_bytes] !== 8'hA5 || bytes_q[s_bytes+1] !== 8'h3C) begin bad++; $display("FAIL cls_bytes: got %p want A5 3C", bytes_q); end
    total++; if (fd_n - s_fd !== 1 || fd_dv - s_fddv !== 1 || fd_at_dv - s_dv !== 2) begin bad++; $display("FAIL cls_fd: got fd=%0d with_dv=%0d at_byte=%0d want 1 1 2", fd_n - s_fd, fd_dv - s_fddv, fd_at_dv - s_dv); end
    send_ones(10);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cls_busy_10: got %b want 1", busy); end
    send_ones(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cls_busy_11: got %b want 0", busy); end
    total++; if (id !== 11'h123 || data_byte !== 8'h3C) begin bad++; $display("FAIL cls_hold: got id=%h byte=%h want 123 3C", id, data_byte); end
  endtask

  task automatic test_remote();
    gap_g = 2;
    snap();
    build_hdr(11'h7FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
    send_bits(1'b1, -1);
    total++; if (hdr_n - s_hdr !== 1 || h_id !== 11'h7FF || h_rem !== 1'b1 || remote !== 1'b1) begin bad++; $display("FAIL rem_hdr: got n=%0d id=%h rem=%b want 1 7ff 1", hdr_n - s_hdr, h_id, h_rem); end
    total++; if (fd_hdr - s_fdhdr !== 1 || fd_n - s_fd !== 1) begin bad++; $display("FAIL rem_fd: got with_hdr=%0d fd=%0d want 1 1", fd_hdr - s_fdhdr, fd_n - s_fd); end
    total++; if (dv_n - s_dv !== 0) begin bad++; $display("FAIL rem_dv: got %0d want 0", dv_n - s_dv); end
    send_ones(11);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rem_idle: got %b want 0", busy); end
    gap_g = 0;
  endtask

  task automatic test_stuff();
    gap_g = 1;
    snap();
    build_hdr(11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    send_bits(1'b1, -1);
    total++; if (hdr_n - s_hdr !== 1 || h_id !== 11'h000 || h_dlc !== 4'd0) begin bad++; $display("FAIL stf_hdr: got n=%0d id=%h dlc=%0d want 1 000 0", hdr_n - s_hdr, h_id, h_dlc); end
    total++; if (serr_n - s_serr !== 0 || fd_hdr - s_fdhdr !== 1) begin bad++; $display("FAIL stf_ok: got serr=%0d fd_hdr=%0d want 0 1", serr_n - s_serr, fd_hdr - s_fdhdr); end
    send_ones(11);
    snap();
    bits_q.delete();
    push(11'd0, 6);
    send_bits(1'b0, -1);
    total++; if (serr_n - s_serr !== 1 || busy !== 1'b1) begin bad++; $display("FAIL stf_err: got serr=%0d busy=%b want 1 1", serr_n - s_serr, busy); end
    send_ones(10);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stf_err_10: got %b want 1", busy); end
    send_ones(1);
    total++; if (busy !== 1'b0 || hdr_n - s_hdr !== 0) begin bad++; $display("FAIL stf_err_idle: got busy=%b hdr=%0d want 0 0", busy, hdr_n - s_hdr); end
    gap_g = 0;
  endtask

  task automatic test_fd();
    snap();
    build_hdr(11'h2A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
    for (int i = 0; i < 12; i++) push({3'd0, 8'(i * 17 + 7)}, 8);
    send_bits(1'b1, -1);
    total++; if ({h_id, h_edl, h_brs, h_esi, h_dlc} !== {11'h2A5, 1'b1, 1'b1, 1'b0, 4'd9}) begin bad++; $display("FAIL fd_hdr: got id=%h edl=%b brs=%b esi=%b dlc=%0d want 2a5 1 1 0 9", h_id, h_edl, h_brs, h_esi, h_dlc); end
    total++; if (dv_n - s_dv !== 12) begin bad++; $display("FAIL fd_dv_cnt: got %0d want 12", dv_n - s_dv); end
    for (int i = 0; i < 12; i++) begin
      total++; if (bytes_q.size() <= s_bytes + i || bytes_q[s_bytes+i] !== 8'(i * 17 + 7)) begin bad++; $display("FAIL fd_byte%0d: got %h want %h", i, (bytes_q.size() > s_bytes + i) ? bytes_q[s_bytes+i] : 8'hxx, 8'(i * 17 + 7)); end
    end
    total++; if (fd_n - s_fd !== 1 || fd_dv - s_fddv !== 1 || fd_at_dv - s_dv !== 12) begin bad++; $display("FAIL fd_done: got fd=%0d with_dv=%0d at_byte=%0d want 1 1 12", fd_n - s_fd, fd_dv - s_fddv, fd_at_dv - s_dv); end
    send_ones(11);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fd_idle: got %b want 0", busy); end
  endtask

  task automatic test_form();
    snap();
    build_hdr(11'h555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    send_bits(1'b1, -1);
    total++; if (ferr_n - s_ferr !== 1 || serr_n - s_serr !== 0) begin bad++; $display("FAIL ide_ferr: got ferr=%0d serr=%0d want 1 0", ferr_n - s_ferr, serr_n - s_serr); end
    send_ones(11);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ide_idle: got %b want 0", busy); end
    build_hdr(11'h0F0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    send_bits(1'b1, -1);
    total++; if (ferr_n - s_ferr !== 2 || serr_n - s_serr !== 0) begin bad++; $display("FAIL res_ferr: got ferr=%0d serr=%0d want 2 0", ferr_n - s_ferr, serr_n - s_serr); end
    send_ones(11);
    total++; if (busy !== 1'b0 || hdr_n - s_hdr !== 0) begin bad++; $display("FAIL res_idle: got busy=%b hdr=%0d want 0 0", busy, hdr_n - s_hdr); end
  endtask

  task automatic test_reset_mid();
    build_hdr(11'h3C1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
    push(11'h96, 8); push(11'h69, 8);
    send_bits(1'b1, 31);
    total++; if (busy !== 1'b1 || data_byte !== 8'h96 || id !== 11'h3C1) begin bad++; $display("FAIL mid_pre: got busy=%b byte=%h id=%h want 1 96 3c1", busy, data_byte, id); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, id, rtr, edl, brs, esi, dlc, remote, data_byte} !== 29'd0) begin bad++; $display("FAIL mid_clear: got %h want 0", {busy, id, rtr, edl, brs, esi, dlc, remote, data_byte}); end
    snap();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); sp = 1'b1; rx_bit = i[0];
    end
    sp_off();
    total++; if (hdr_n + dv_n + fd_n + serr_n + ferr_n - s_hdr - s_dv - s_fd - s_serr - s_ferr !== 0 || busy !== 1'b0) begin bad++; $display("FAIL mid_quiet: got events=%0d busy=%b want 0 0", hdr_n + dv_n + fd_n + serr_n + ferr_n - s_hdr - s_dv - s_fd - s_serr - s_ferr, busy); end
    rst_n = 1'b1;
    @(negedge clk);
    test_classical();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_classical();
    test_remote();
    test_stuff();
    test_fd();
    test_form();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
